bcd_seg_scanner: RTL and testbench
==================================

BCD_SEG_SCANNER -- requirements
Module: bcd_seg_scanner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter CLK_DIV, default 1000, SHALL set the cycles each digit is driven (legal range 2..65535).
REQ-003 Parameter GAP_CYC, default 4, SHALL set the all-off ghosting gap in cycles after each digit (legal range 1..255).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 bcd_in  input  12  BCD value: [3:0] ones, [7:4] tens, [11:8] hundreds (upstream binary-to-BCD output).
REQ-007 load  input  1  capture strobe for bcd_in, sampled each rising edge.
REQ-008 lzb  input  1  leading-zero blanking enable.
REQ-009 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}, registered.
REQ-010 an  output  3  active-low digit enables, an[0] = ones, registered.
REQ-011 frame_tick  output  1  one-cycle pulse at the start of each scan frame, registered.
REQ-012 digit_err  output  1  high while the displayed value holds any nibble >9, registered.

Function
REQ-013 FSM states SHALL be SHOW0, GAP0, SHOW1, GAP1, SHOW2, GAP2; SHOWk lasts CLK_DIV cycles, GAPk lasts GAP_CYC cycles; order SHOW0->GAP0->SHOW1->GAP1->SHOW2->GAP2->SHOW0.
REQ-014 In SHOWk, an SHALL have only bit k low; in GAPk, an = 3'b111 and seg = 7'h7F.
REQ-015 Outputs SHALL be registered: they reflect the state and counter with exactly one cycle of latency.
REQ-016 Frame period SHALL be 3*(CLK_DIV+GAP_CYC) cycles.
REQ-017 The block SHALL hold a shadow register and an active register; the displayed digits come from the active register only.
REQ-018 load=1 SHALL write bcd_in into the shadow register and set the pending flag.
REQ-019 On the GAP2->SHOW0 transition (commit edge) with pending set, the shadow register SHALL copy to the active register and pending SHALL clear.
REQ-020 If load=1 on the commit edge, bcd_in SHALL go directly to active, the shadow register SHALL also take bcd_in, and pending SHALL clear.
REQ-021 Loads outside the commit edge SHALL NOT alter the active register; this prevents mid-frame tearing.
REQ-022 Back-to-back loads before a commit SHALL keep only the last value.
REQ-023 Segment codes SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-024 Nibbles 10..15 SHALL display dash 7'h3F.
REQ-025 With lzb=1, the hundreds digit SHALL blank (7'h7F) if it is 0.
REQ-026 With lzb=1, the tens digit SHALL blank if it is 0 and the hundreds digit is blanked.
REQ-027 The ones digit SHALL never blank.
REQ-028 An invalid nibble SHALL count as nonzero for blanking.
REQ-029 lzb SHALL take effect live, from the next digit slot, without a commit.
REQ-030 frame_tick SHALL be 1 for exactly the first output cycle of SHOW0, and SHALL NOT assert on the first SHOW0 after reset.
REQ-031 digit_err SHALL update one cycle after each commit edge.
REQ-032 The per-state counter SHALL reset to 0 on every state transition, with no terminal-count overrun.

Reset
REQ-033 While rst=1 at a rising edge: seg=7'h7F, an=3'b111, frame_tick=0, digit_err=0; active register, shadow register, pending flag and counter all clear to 0; state = SHOW0.
REQ-034 rst SHALL take priority over load on the same edge.
REQ-035 rst asserted mid-frame SHALL abort the scan at the next edge.
REQ-036 After rst deasserts, an=3'b110 with seg=7'h40 SHALL appear one edge later and last CLK_DIV cycles.

Verification (CLK_DIV=4, GAP_CYC=1, frame = 15 cycles)
REQ-037 Reset, load 12'h255, lzb=0 -> after the next commit, per frame: an=110/seg=12 (4 cycles), gap, an=101/seg=12, gap, an=011/seg=24; digit_err=0.
REQ-038 lzb=1, load 12'h007 -> hundreds and tens slots seg=7F with an low; ones seg=78. Then load 12'h000 -> ones seg=40, others blank.
REQ-039 Load 12'h1A3 -> tens seg=3F, hundreds seg=79, ones seg=30; digit_err=1 one cycle after the commit edge; a later valid load clears it.
REQ-040 Load 12'h999 during SHOW1, then 12'h123 during SHOW2 -> the current frame still shows the old value; the next frame shows 1,2,3; 12'h999 is never displayed.
REQ-041 Load on the exact commit edge -> the value is displayed in that same SHOW0 slot.
REQ-042 rst pulsed for 1 cycle during SHOW2 -> next edge an=111/seg=7F; restart at SHOW0 showing 0; no frame_tick; frame_tick then recurs every 15 cycles.

Source files
------------

// File: rtl/bcd_seg_scanner.sv
// -----------------------------------------------------------------------------
// bcd_seg_scanner
// Time-multiplexed driver for a 3-digit common-anode 7-segment display.
// Each digit is driven for CLK_DIV cycles, followed by an all-off gap of
// GAP_CYC cycles to suppress ghosting. New values are double-buffered
// (shadow -> active) and only committed at the frame boundary, so a frame
// never shows a mix of old and new digits.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   bcd_in     in   [11:8] hundreds, [7:4] tens, [3:0] ones
//   load       in   capture strobe for bcd_in
//   lzb        in   leading-zero blanking enable (applies live)
//   seg        out  active-low segments {g,f,e,d,c,b,a}, registered
//   an         out  active-low digit enables, an[0] = ones, registered
//   frame_tick out  one-cycle pulse on the first output cycle of each frame
//   digit_err  out  high while the displayed value holds a nibble > 9
// -----------------------------------------------------------------------------
module bcd_seg_scanner #(
    parameter int CLK_DIV = 1000,
    parameter int GAP_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        load,
    input  logic        lzb,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame_tick,
    output logic        digit_err
);

    typedef enum logic [2:0] {SHOW0, GAP0, SHOW1, GAP1, SHOW2, GAP2} state_t;

    localparam logic [15:0] SHOW_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic        last;
    logic        commit;

    logic [11:0] active, shadow;
    logic        pending;
    // Set once the first frame has wrapped; keeps frame_tick quiet on the
    // very first SHOW0 after reset.
    logic        wrapped;

    logic        blank_hund, blank_tens;
    logic [6:0]  seg_nxt;
    logic [2:0]  an_nxt;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h3F;   // dash for non-BCD nibbles
        endcase
    endfunction

    function automatic logic nib_bad(input logic [3:0] d);
        nib_bad = (d > 4'd9);
    endfunction

    // ---------------- scan sequencer ----------------
    always_comb begin
        state_nxt = state;
        last      = 1'b0;
        case (state)
            SHOW0, SHOW1, SHOW2: last = (cnt == SHOW_LAST);
            default:             last = (cnt == GAP_LAST);
        endcase
        if (last) begin
            case (state)
                SHOW0:   state_nxt = GAP0;
                GAP0:    state_nxt = SHOW1;
                SHOW1:   state_nxt = GAP1;
                GAP1:    state_nxt = SHOW2;
                SHOW2:   state_nxt = GAP2;
                GAP2:    state_nxt = SHOW0;
                default: state_nxt = SHOW0;
            endcase
        end
    end

    assign commit = (state == GAP2) && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SHOW0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= last ? 16'd0 : cnt + 16'd1;
        end
    end

    // ---------------- shadow / active buffering ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            wrapped <= 1'b0;
        end else if (commit) begin
            // A load landing exactly on the commit edge bypasses the shadow.
            if (load) begin
                active <= bcd_in;
                shadow <= bcd_in;
            end else if (pending) begin
                active <= shadow;
            end
            pending <= 1'b0;
            wrapped <= 1'b1;
        end else if (load) begin
            shadow  <= bcd_in;
            pending <= 1'b1;
        end
    end

    // ---------------- output decode ----------------
    // Invalid nibbles compare nonzero, so they are never blanked.
    assign blank_hund = lzb && (active[11:8] == 4'd0);
    assign blank_tens = blank_hund && (active[7:4] == 4'd0);

    always_comb begin
        seg_nxt = 7'h7F;
        an_nxt  = 3'b111;
        case (state)
            SHOW0: begin
                an_nxt  = 3'b110;
                seg_nxt = seg_code(active[3:0]);
            end
            SHOW1: begin
                an_nxt  = 3'b101;
                seg_nxt = blank_tens ? 7'h7F : seg_code(active[7:4]);
            end
            SHOW2: begin
                an_nxt  = 3'b011;
                seg_nxt = blank_hund ? 7'h7F : seg_code(active[11:8]);
            end
            default: begin
                seg_nxt = 7'h7F;
                an_nxt  = 3'b111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= 7'h7F;
            an         <= 3'b111;
            frame_tick <= 1'b0;
            digit_err  <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= (state == SHOW0) && (cnt == 16'd0) && wrapped;
            digit_err  <= nib_bad(active[3:0]) | nib_bad(active[7:4]) |
                          nib_bad(active[11:8]);
        end
    end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_bcd_seg_scanner
// Directed bench for bcd_seg_scanner with CLK_DIV=4, GAP_CYC=1 (15-cycle
// frame). The stimulus process drives one frame at a time and pushes the
// hand-computed expectation for each digit slot of that frame into a queue;
// the monitor pops one entry whenever the DUT opens a new digit slot.
// -----------------------------------------------------------------------------
module tb_bcd_seg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bcd_in;
    logic        load;
    logic        lzb;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame_tick;
    logic        digit_err;

    bcd_seg_scanner #(.CLK_DIV(4), .GAP_CYC(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .load       (load),
        .lzb        (lzb),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick),
        .digit_err  (digit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] an;
        logic [6:0] seg;
        logic       tick;
        logic       err;
        int         len;
    } slot_t;

    slot_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic       mon_en  = 1'b0;
    logic [2:0] prev_an = 3'b111;
    int         cur_len = 0;
    int         exp_len = 0;
    logic [6:0] cur_seg = 7'h7F;

    always @(negedge clk) begin
        if (mon_en) begin
            if (an !== 3'b111) begin
                if (an !== prev_an) begin
                    if (prev_an !== 3'b111) chk("slot_len", cur_len, exp_len);
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_slot: got an=%b seg=%h, expected no slot", an, seg);
                        cur_len = 1;
                        exp_len = 1;
                        cur_seg = seg;
                    end else begin
                        slot_t r;
                        r = q.pop_front();
                        chk("slot_an",   an,         r.an);
                        chk("slot_seg",  seg,        r.seg);
                        chk("slot_tick", frame_tick, r.tick);
                        chk("slot_err",  digit_err,  r.err);
                        cur_len = 1;
                        exp_len = r.len;
                        cur_seg = r.seg;
                    end
                end else begin
                    cur_len++;
                    chk("seg_hold", seg, cur_seg);
                    chk("tick_mid", frame_tick, 1'b0);
                end
            end else begin
                chk("gap_seg",  seg, 7'h7F);
                chk("gap_tick", frame_tick, 1'b0);
                if (prev_an !== 3'b111) chk("slot_len", cur_len, exp_len);
            end
            prev_an = an;
        end
    end

    // ---------------- stimulus ----------------
    // One frame starting at the next rising edge. Offsets k = 0..14 name the
    // edge within the frame at which load/rst is sampled; -1 means unused.
    task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input logic err, input logic tick, input logic lzb_v,
                             input int ld1_off, input logic [11:0] ld1_val,
                             input int ld2_off, input logic [11:0] ld2_val,
                             input int rst_off);
        slot_t r;
        r.an = 3'b110; r.seg = s0; r.tick = tick;  r.err = err; r.len = 4; q.push_back(r);
        r.an = 3'b101; r.seg = s1; r.tick = 1'b0;  r.err = err; r.len = 4; q.push_back(r);
        r.an = 3'b011; r.seg = s2; r.tick = 1'b0;  r.err = err;
        r.len = (rst_off >= 0) ? rst_off - 10 : 4;
        q.push_back(r);
        lzb = lzb_v;
        for (int k = 0; k < 15; k++) begin
            load   = (k == ld1_off) || (k == ld2_off);
            bcd_in = (k == ld1_off) ? ld1_val : ((k == ld2_off) ? ld2_val : 12'hEEE);
            rst    = (k == rst_off);
            @(negedge clk);
            load   = 1'b0;
            bcd_in = 12'hEEE;
            if (rst) begin
                rst = 1'b0;
                chk("midrst_an",   an,         3'b111);
                chk("midrst_seg",  seg,        7'h7F);
                chk("midrst_tick", frame_tick, 1'b0);
                chk("midrst_err",  digit_err,  1'b0);
                return;
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        bcd_in = 12'h000;
        lzb    = 1'b0;
        repeat (2) @(negedge clk);
        // load on a reset edge must be ignored
        load   = 1'b1;
        bcd_in = 12'h888;
        @(negedge clk);
        load   = 1'b0;
        bcd_in = 12'hEEE;
        chk("rst_seg",  seg,        7'h7F);
        chk("rst_an",   an,         3'b111);
        chk("rst_tick", frame_tick, 1'b0);
        chk("rst_err",  digit_err,  1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;

        //          s0     s1     s2     err   tick  lzb   ld1          ld2          rst
        run_frame(7'h40, 7'h40, 7'h40, 1'b0, 1'b0, 1'b0,  5, 12'h255, -1, 12'h000, -1);
        run_frame(7'h12, 7'h12, 7'h24, 1'b0, 1'b1, 1'b0,  3, 12'h007, -1, 12'h000, -1);
        run_frame(7'h78, 7'h7F, 7'h7F, 1'b0, 1'b1, 1'b1,  7, 12'h000, -1, 12'h000, -1);
        run_frame(7'h40, 7'h7F, 7'h7F, 1'b0, 1'b1, 1'b1,  0, 12'h1A3, -1, 12'h000, -1);
        run_frame(7'h30, 7'h3F, 7'h79, 1'b1, 1'b1, 1'b1, 12, 12'h010, -1, 12'h000, -1);
        run_frame(7'h40, 7'h79, 7'h7F, 1'b0, 1'b1, 1'b1,  6, 12'h999, 11, 12'h123, -1);
        run_frame(7'h30, 7'h24, 7'h79, 1'b0, 1'b1, 1'b0, 14, 12'h486, -1, 12'h000, -1);
        run_frame(7'h02, 7'h00, 7'h19, 1'b0, 1'b1, 1'b0,  2, 12'h105, -1, 12'h000, -1);
        run_frame(7'h12, 7'h40, 7'h79, 1'b0, 1'b1, 1'b1,  4, 12'h0F0, -1, 12'h000, -1);
        run_frame(7'h40, 7'h3F, 7'h7F, 1'b1, 1'b1, 1'b1, -1, 12'h000, -1, 12'h000, -1);
        run_frame(7'h40, 7'h3F, 7'h40, 1'b1, 1'b1, 1'b0,  3, 12'h321, -1, 12'h000, 11);
        run_frame(7'h40, 7'h40, 7'h40, 1'b0, 1'b0, 1'b0, -1, 12'h000, -1, 12'h000, -1);
        run_frame(7'h40, 7'h40, 7'h40, 1'b0, 1'b1, 1'b0, -1, 12'h000, -1, 12'h000, -1);

        @(posedge clk);
        mon_en = 1'b0;
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
